// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register for the ALU path: decodes the ALU Operation code in ID,
// holds or bubbles on hazard-unit request, and forwards EX/MEM and MEM/WB results into the EX operands.
module id_ex_alu_issue #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [1:0]                id_alu_op,
    input  logic [2:0]                id_funct3,
    input  logic                      id_funct7_b5,
    input  logic                      id_alu_src,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic                      id_reg_write,
    input  logic                      exmem_reg_write,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output logic                      ex_valid,
    output logic [OPCODE_LENGTH-1:0]  ex_operation,
    output logic [DATA_WIDTH-1:0]     ex_src_a,
    output logic [DATA_WIDTH-1:0]     ex_src_b,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    output logic                      ex_reg_write
);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_NE  = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] OP_LT  = OPCODE_LENGTH'(4'b1010);
    localparam logic [OPCODE_LENGTH-1:0] OP_GE  = OPCODE_LENGTH'(4'b1011);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] OP_UNS = OPCODE_LENGTH'(4'b1111);

    logic [OPCODE_LENGTH-1:0]  id_operation;

    logic                      valid_q,     valid_d;
    logic [OPCODE_LENGTH-1:0]  operation_q, operation_d;
    logic                      alu_src_q,   alu_src_d;
    logic [DATA_WIDTH-1:0]     rs1_data_q,  rs1_data_d;
    logic [DATA_WIDTH-1:0]     rs2_data_q,  rs2_data_d;
    logic [DATA_WIDTH-1:0]     imm_q,       imm_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_q,  rs1_addr_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_q,  rs2_addr_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q,   rd_addr_d;
    logic                      reg_write_q, reg_write_d;

    logic [DATA_WIDTH-1:0]     fwd_rs1;
    logic [DATA_WIDTH-1:0]     fwd_rs2;

    always_comb begin
        id_operation = OP_UNS;
        unique case (id_alu_op)
            2'b00: id_operation = OP_ADD;
            2'b01: begin
                unique case (id_funct3)
                    3'b000:  id_operation = OP_EQ;
                    3'b001:  id_operation = OP_NE;
                    3'b100:  id_operation = OP_LT;
                    3'b101:  id_operation = OP_GE;
                    default: id_operation = OP_UNS;
                endcase
            end
            default: begin
                // I-type ignores bit 30 for funct3=000 since ADDI has no SUB form
                unique case (id_funct3)
                    3'b000:  id_operation = (id_funct7_b5 && id_alu_op == 2'b10) ? OP_SUB : OP_ADD;
                    3'b001:  id_operation = OP_SLL;
                    3'b010:  id_operation = OP_SLT;
                    3'b011:  id_operation = OP_UNS;
                    3'b100:  id_operation = OP_XOR;
                    3'b101:  id_operation = id_funct7_b5 ? OP_SRA : OP_SRL;
                    3'b110:  id_operation = OP_OR;
                    default: id_operation = OP_AND;
                endcase
            end
        endcase
    end

    always_comb begin
        valid_d     = valid_q;
        operation_d = operation_q;
        alu_src_d   = alu_src_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rd_addr_d   = rd_addr_q;
        reg_write_d = reg_write_q;
        if (flush) begin
            valid_d     = 1'b0;
            operation_d = OP_ADD;
            alu_src_d   = 1'b0;
            rs1_data_d  = '0;
            rs2_data_d  = '0;
            imm_d       = '0;
            rs1_addr_d  = '0;
            rs2_addr_d  = '0;
            rd_addr_d   = '0;
            reg_write_d = 1'b0;
        end else if (!stall) begin
            valid_d     = id_valid;
            operation_d = id_operation;
            alu_src_d   = id_alu_src;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            rs1_addr_d  = id_rs1_addr;
            rs2_addr_d  = id_rs2_addr;
            rd_addr_d   = id_rd_addr;
            reg_write_d = id_reg_write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            operation_q <= OP_ADD;
            alu_src_q   <= 1'b0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            operation_q <= operation_d;
            alu_src_q   <= alu_src_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_addr_q   <= rd_addr_d;
            reg_write_q <= reg_write_d;
        end
    end

    // EX/MEM is younger than MEM/WB, so it wins when both target the same register
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs1_addr_q) begin
            fwd_rs1 = exmem_result;
        end else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs1_addr_q) begin
            fwd_rs1 = memwb_result;
        end
    end

    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs2_addr_q) begin
            fwd_rs2 = exmem_result;
        end else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs2_addr_q) begin
            fwd_rs2 = memwb_result;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_operation  = operation_q;
    assign ex_src_a      = fwd_rs1;
    assign ex_store_data = fwd_rs2;
    assign ex_src_b      = alu_src_q ? imm_q : fwd_rs2;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_reg_write  = reg_write_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue: directed test-plan sequences followed by random traffic,
// with expected EX outputs produced by a behavioural model and checked by an independent monitor.
module tb_id_ex_alu_issue;

    typedef struct {
        logic        reset, stall, flush, id_valid;
        logic [1:0]  alu_op;
        logic [2:0]  funct3;
        logic        b5, alu_src, id_rw;
        logic [31:0] rs1_data, rs2_data, imm;
        logic [4:0]  rs1_addr, rs2_addr, rd_addr;
        logic        exmem_rw, memwb_rw;
        logic [4:0]  exmem_rd, memwb_rd;
        logic [31:0] exmem_res, memwb_res;
    } stim_t;

    typedef struct {
        logic        valid, rw, alu_src;
        logic [3:0]  op;
        logic [31:0] rs1_data, rs2_data, imm;
        logic [4:0]  rs1_addr, rs2_addr, rd;
    } mstate_t;

    typedef struct {
        logic        valid, rw;
        logic [3:0]  op;
        logic [31:0] a, b, store;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid, id_funct7_b5, id_alu_src, id_reg_write;
    logic [1:0]  id_alu_op;
    logic [2:0]  id_funct3;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, exmem_result, memwb_result;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic        ex_valid, ex_reg_write;
    logic [3:0]  ex_operation;
    logic [31:0] ex_src_a, ex_src_b, ex_store_data;
    logic [4:0]  ex_rd_addr;

    int checks = 0;
    int errors = 0;
    exp_t    exp_q[$];
    mstate_t st;
    stim_t   cur;

    always #5 clk = ~clk;

    id_ex_alu_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct3(id_funct3),
        .id_funct7_b5(id_funct7_b5), .id_alu_src(id_alu_src),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_reg_write(id_reg_write),
        .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_operation(ex_operation),
        .ex_src_a(ex_src_a), .ex_src_b(ex_src_b), .ex_store_data(ex_store_data),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write)
    );

    // Operation code straight from the decode table
    function automatic logic [3:0] model_op(input logic [1:0] alu_op, input logic [2:0] f3, input logic b5);
        logic [3:0] rtab [8];
        rtab = '{4'b0010, 4'b0011, 4'b0111, 4'b1111, 4'b1100, 4'b0100, 4'b0001, 4'b0000};
        if (alu_op == 2'b00) return 4'b0010;
        if (alu_op == 2'b01) begin
            if (f3 == 3'd0) return 4'b1000;
            if (f3 == 3'd1) return 4'b1001;
            if (f3 == 3'd4) return 4'b1010;
            if (f3 == 3'd5) return 4'b1011;
            return 4'b1111;
        end
        if (f3 == 3'd0 && alu_op == 2'b10 && b5) return 4'b0101;
        if (f3 == 3'd5 && b5) return 4'b0110;
        return rtab[f3];
    endfunction

    function automatic logic [31:0] model_fwd(input logic [4:0] rs, input logic [31:0] rf, input stim_t s);
        if (s.exmem_rw && s.exmem_rd != 0 && s.exmem_rd == rs) return s.exmem_res;
        if (s.memwb_rw && s.memwb_rd != 0 && s.memwb_rd == rs) return s.memwb_res;
        return rf;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.reset = 0; s.stall = 0; s.flush = 0; s.id_valid = 0;
        s.alu_op = 0; s.funct3 = 0; s.b5 = 0; s.alu_src = 0; s.id_rw = 0;
        s.rs1_data = 0; s.rs2_data = 0; s.imm = 0;
        s.rs1_addr = 0; s.rs2_addr = 0; s.rd_addr = 0;
        s.exmem_rw = 0; s.memwb_rw = 0; s.exmem_rd = 0; s.memwb_rd = 0;
        s.exmem_res = 0; s.memwb_res = 0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.reset    = ($urandom_range(0, 99) < 3);
        s.flush    = ($urandom_range(0, 99) < 10);
        s.stall    = ($urandom_range(0, 99) < 25);
        s.id_valid = 1'($urandom);
        s.alu_op   = 2'($urandom);
        s.funct3   = 3'($urandom);
        s.b5       = 1'($urandom);
        s.alu_src  = 1'($urandom);
        s.id_rw    = 1'($urandom);
        s.rs1_data = $urandom; s.rs2_data = $urandom; s.imm = $urandom;
        s.rs1_addr = 5'($urandom_range(0, 7));
        s.rs2_addr = 5'($urandom_range(0, 7));
        s.rd_addr  = 5'($urandom);
        s.exmem_rw = 1'($urandom); s.memwb_rw = 1'($urandom);
        s.exmem_rd = 5'($urandom_range(0, 7));
        s.memwb_rd = 5'($urandom_range(0, 7));
        s.exmem_res = $urandom; s.memwb_res = $urandom;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        reset = s.reset; stall = s.stall; flush = s.flush; id_valid = s.id_valid;
        id_alu_op = s.alu_op; id_funct3 = s.funct3; id_funct7_b5 = s.b5;
        id_alu_src = s.alu_src; id_reg_write = s.id_rw;
        id_rs1_data = s.rs1_data; id_rs2_data = s.rs2_data; id_imm = s.imm;
        id_rs1_addr = s.rs1_addr; id_rs2_addr = s.rs2_addr; id_rd_addr = s.rd_addr;
        exmem_reg_write = s.exmem_rw; memwb_reg_write = s.memwb_rw;
        exmem_rd = s.exmem_rd; memwb_rd = s.memwb_rd;
        exmem_result = s.exmem_res; memwb_result = s.memwb_res;
    endtask

    // One cycle: the model absorbs the inputs seen at this edge, then new inputs go out
    // and the expected EX view (registered state + new forwarding inputs) is queued.
    task automatic step(input stim_t s);
        exp_t e;
        @(posedge clk);
        if (cur.reset || cur.flush) begin
            st.valid = 0; st.rw = 0; st.alu_src = 0; st.op = 4'b0010;
            st.rs1_data = 0; st.rs2_data = 0; st.imm = 0;
            st.rs1_addr = 0; st.rs2_addr = 0; st.rd = 0;
        end else if (!cur.stall) begin
            st.valid = cur.id_valid; st.rw = cur.id_rw; st.alu_src = cur.alu_src;
            st.op = model_op(cur.alu_op, cur.funct3, cur.b5);
            st.rs1_data = cur.rs1_data; st.rs2_data = cur.rs2_data; st.imm = cur.imm;
            st.rs1_addr = cur.rs1_addr; st.rs2_addr = cur.rs2_addr; st.rd = cur.rd_addr;
        end
        #1;
        drive(s);
        cur = s;
        e.valid = st.valid; e.rw = st.rw; e.op = st.op; e.rd = st.rd;
        e.a     = model_fwd(st.rs1_addr, st.rs1_data, s);
        e.store = model_fwd(st.rs2_addr, st.rs2_data, s);
        e.b     = st.alu_src ? st.imm : e.store;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ex_valid",      32'(ex_valid),      32'(e.valid));
                chk("ex_reg_write",  32'(ex_reg_write),  32'(e.rw));
                chk("ex_operation",  32'(ex_operation),  32'(e.op));
                chk("ex_rd_addr",    32'(ex_rd_addr),    32'(e.rd));
                chk("ex_src_a",      ex_src_a,           e.a);
                chk("ex_src_b",      ex_src_b,           e.b);
                chk("ex_store_data", ex_store_data,      e.store);
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        cur = idle();
        cur.reset = 1;
        drive(cur);
        st = '{default: '0};
        s = idle(); s.reset = 1;
        step(s);
        step(s);

        // Decode sweep over R-type, then branch / I-type / load-store examples
        for (int unsigned f = 0; f < 8; f++) begin
            for (int unsigned b = 0; b < 2; b++) begin
                s = idle(); s.id_valid = 1; s.alu_op = 2'b10;
                s.funct3 = 3'(f); s.b5 = 1'(b); s.rd_addr = 5'(f + 1);
                step(s);
            end
        end
        s = idle(); s.id_valid = 1; s.alu_op = 2'b01; s.funct3 = 3'd5; step(s);
        s = idle(); s.id_valid = 1; s.alu_op = 2'b11; s.funct3 = 3'd0; s.b5 = 1; step(s);
        s = idle(); s.id_valid = 1; s.alu_op = 2'b11; s.funct3 = 3'd5; s.b5 = 1; step(s);
        s = idle(); s.id_valid = 1; s.alu_op = 2'b00; s.funct3 = 3'd7; step(s);

        // Forwarding priority on rs1 (and rs2 sharing the same register)
        s = idle(); s.id_valid = 1; s.rs1_addr = 5; s.rs2_addr = 5;
        s.rs1_data = 32'h0000_AAAA; s.rs2_data = 32'h0000_BBBB;
        step(s);
        s.stall = 1; s.exmem_rw = 1; s.memwb_rw = 1;
        s.exmem_rd = 5; s.memwb_rd = 5; s.exmem_res = 32'h11; s.memwb_res = 32'h22;
        step(s);
        s.exmem_rw = 0; step(s);
        s.exmem_rd = 0; s.memwb_rd = 0; s.exmem_rw = 1; step(s);

        // alu_src selects the immediate while store data keeps the forwarded rs2
        s = idle(); s.id_valid = 1; s.alu_src = 1; s.imm = 32'hFFFF_FFF0;
        s.rs2_addr = 9; s.rs2_data = 32'h1;
        step(s);
        s.stall = 1; s.exmem_rw = 1; s.exmem_rd = 9; s.exmem_res = 32'h33;
        step(s);

        // Stall holds a loaded ADD, then flush wins over stall
        s = idle(); s.id_valid = 1; s.id_rw = 1; s.alu_op = 2'b10; s.rd_addr = 7;
        step(s);
        for (int unsigned k = 0; k < 3; k++) begin
            s = rand_stim(); s.reset = 0; s.flush = 0; s.stall = 1;
            step(s);
        end
        s = idle(); s.stall = 1; s.flush = 1; step(s);
        s = idle(); step(s);

        // Reset during a valid SUB, including reset while stalled
        s = idle(); s.id_valid = 1; s.id_rw = 1; s.alu_op = 2'b10; s.b5 = 1; s.rd_addr = 12;
        step(s);
        s.stall = 1; step(s);
        s.reset = 1; step(s);
        s = idle(); step(s);

        for (int unsigned n = 0; n < 500; n++) begin
            step(rand_stim());
        end
        step(idle());

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
